// File: rtl/vga_pkg.sv
// Shared definitions for the VGA capture path: default frame geometry, bus widths,
// FSM state encoding and a saturating counter helper.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int ADDR_W       = 19;
    localparam int COLOR_W      = 12;
    localparam int CNT_W        = 10;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        FRAME = 2'd2
    } state_e;

    // Counters stick at their maximum instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Rise/fall detector for one VGA input; the history register only advances on pix_en,
// so edges are measured in VGA pixels rather than system clocks.
module vga_edge_det #(
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pix_en,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = prev_q;
        if (pix_en) begin
            prev_d = sig_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= INIT;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = pix_en &  sig_in & ~prev_q;
    assign fall = pix_en & ~sig_in &  prev_q;

endmodule

// File: rtl/vga_capture.sv
// Receive side of the VGA pixel stream: rebuilds (x,y) from valid/vsync edges and writes
// each active pixel, reduced to 4:4:4 colour, into the frame RAM at {x, y[8:0]}.
module vga_capture
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_en,
    input  logic               start,
    input  logic               continuous,
    input  logic               hsync,
    input  logic               vsync,
    input  logic               valid,
    input  logic [7:0]         red,
    input  logic [7:0]         green,
    input  logic [7:0]         blue,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [COLOR_W-1:0] wr_data,
    output logic               busy,
    output logic               frame_done,
    output logic               line_err,
    output logic               frame_err,
    output logic [CNT_W-1:0]   lines_seen
);

    localparam logic [CNT_W-1:0] H_LIM = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_LIM = CNT_W'(V_ACTIVE);

    state_e state_q, state_d;
    logic [CNT_W-1:0]   x_q, x_d;
    logic [CNT_W-1:0]   y_q, y_d;
    logic [CNT_W-1:0]   y_close;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [COLOR_W-1:0] wr_data_q, wr_data_d;
    logic               frame_done_q, frame_done_d;
    logic               line_err_q, line_err_d;
    logic               frame_err_q, frame_err_d;
    logic [CNT_W-1:0]   lines_seen_q, lines_seen_d;

    logic vs_rise, vs_fall, vs_assert;
    logic valid_rise, valid_fall;
    logic unused_inputs;

    // History resets to the inactive sync level so the first active sample counts as an edge.
    vga_edge_det #(.INIT(!SYNC_POL)) u_vsync_det (
        .clk    (clk),
        .reset  (reset),
        .pix_en (pix_en),
        .sig_in (vsync),
        .rise   (vs_rise),
        .fall   (vs_fall)
    );

    vga_edge_det #(.INIT(1'b0)) u_valid_det (
        .clk    (clk),
        .reset  (reset),
        .pix_en (pix_en),
        .sig_in (valid),
        .rise   (valid_rise),
        .fall   (valid_fall)
    );

    assign vs_assert     = SYNC_POL ? vs_rise : vs_fall;
    assign unused_inputs = ^{hsync, valid_rise, red[3:0], green[3:0], blue[3:0]};

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        y_close      = y_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        line_err_d   = line_err_q;
        frame_err_d  = frame_err_q;
        lines_seen_d = lines_seen_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = ARM;
                    line_err_d  = 1'b0;
                    frame_err_d = 1'b0;
                    x_d         = '0;
                    y_d         = '0;
                end
            end

            ARM: begin
                if (vs_assert) begin
                    state_d = FRAME;
                    x_d     = '0;
                    y_d     = '0;
                end
            end

            FRAME: begin
                if (pix_en && valid) begin
                    if (x_q < H_LIM && y_q < V_LIM) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = {x_q, y_q[8:0]};
                        wr_data_d = {red[7:4], green[7:4], blue[7:4]};
                    end
                    x_d = sat_inc(x_q);
                end

                // A line closing on the same pixel as vsync is counted before the frame closes.
                if (valid_fall) begin
                    if (x_q != H_LIM) begin
                        line_err_d = 1'b1;
                    end
                    y_close = sat_inc(y_q);
                    x_d     = '0;
                    y_d     = y_close;
                end

                if (vs_assert) begin
                    frame_done_d = 1'b1;
                    lines_seen_d = y_close;
                    if (y_close != V_LIM) begin
                        frame_err_d = 1'b1;
                    end
                    x_d     = '0;
                    y_d     = '0;
                    state_d = continuous ? ARM : IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            lines_seen_q <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            line_err_q   <= line_err_d;
            frame_err_q  <= frame_err_d;
            lines_seen_q <= lines_seen_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;
    assign line_err   = line_err_q;
    assign frame_err  = frame_err_q;
    assign lines_seen = lines_seen_q;

endmodule

// File: tb/tb_vga_capture.sv
// Self-checking bench for vga_capture on a reduced 16x12 frame: random pixel colours,
// expected RAM writes and flags predicted per frame from the stream that is generated.
module tb_vga_capture;

    localparam int H = 16;
    localparam int V = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_en;
    logic        start;
    logic        continuous;
    logic        hsync;
    logic        vsync;
    logic        valid;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        wr_en;
    logic [18:0] wr_addr;
    logic [11:0] wr_data;
    logic        busy;
    logic        frame_done;
    logic        line_err;
    logic        frame_err;
    logic [9:0]  lines_seen;

    vga_capture #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .SYNC_POL (1'b0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_en     (pix_en),
        .start      (start),
        .continuous (continuous),
        .hsync      (hsync),
        .vsync      (vsync),
        .valid      (valid),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .frame_done (frame_done),
        .line_err   (line_err),
        .frame_err  (frame_err),
        .lines_seen (lines_seen)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Scoreboard of writes the frame RAM should receive, oldest first.
    logic [18:0] exp_addr[$];
    logic [11:0] exp_data[$];

    int          pix_div    = 1;
    int          write_cnt  = 0;
    int          done_cnt   = 0;
    logic        probe_seen = 1'b0;
    logic [11:0] probe_data = '0;
    logic        want_first = 1'b0;
    logic        first_seen = 1'b0;
    logic [18:0] first_addr = '0;
    logic        prev_wr    = 1'b0;

    // Frame-level model of the capture: whether the stream is armed/being captured,
    // how many lines the current frame has had, and the flags those lines imply.
    bit m_armed      = 1'b0;
    bit m_cap        = 1'b0;
    bit m_line_err   = 1'b0;
    bit m_frame_err  = 1'b0;
    int m_lines      = 0;
    int m_exp_done   = 0;
    int m_lines_seen = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every RAM write is matched against the scoreboard as it appears.
    always @(negedge clk) begin
        if (wr_en) begin
            checkOutput("write expected", 32'(exp_addr.size() != 0), 32'd1);
            if (exp_addr.size() != 0) begin
                checkOutput("wr_addr", 32'(wr_addr), 32'(exp_addr.pop_front()));
                checkOutput("wr_data", 32'(wr_data), 32'(exp_data.pop_front()));
            end
            write_cnt++;
            if (wr_addr == 19'h00A07) begin
                probe_seen = 1'b1;
                probe_data = wr_data;
            end
            if (want_first) begin
                first_addr = wr_addr;
                first_seen = 1'b1;
                want_first = 1'b0;
            end
            if (pix_div > 1) begin
                checkOutput("wr_en back-to-back", 32'(prev_wr), 32'd0);
            end
        end
        if (frame_done) begin
            done_cnt++;
            want_first = 1'b1;
        end
        prev_wr = wr_en;
    end

    // One VGA pixel period: pix_en high for one clk out of every pix_div.
    task automatic applyStimulus(input logic hs, input logic vs, input logic vl,
                                 input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        for (int k = 0; k < pix_div - 1; k++) begin
            pix_en = 1'b0;
            @(posedge clk);
            #1;
        end
        hsync  = hs;
        vsync  = vs;
        valid  = vl;
        red    = r;
        green  = g;
        blue   = b;
        pix_en = 1'b1;
        @(posedge clk);
        #1;
        pix_en = 1'b0;
    endtask

    task automatic send_line(input int len, input bit blank);
        logic [7:0] r, g, b;
        for (int x = 0; x < len; x++) begin
            r = 8'($urandom);
            g = 8'($urandom);
            b = 8'($urandom);
            if (x == 5 && m_lines == 7) begin
                r = 8'hA5;
                g = 8'h3C;
                b = 8'hF0;
            end
            if (m_cap && x < H && m_lines < V) begin
                exp_addr.push_back({10'(x), 9'(m_lines)});
                exp_data.push_back({r[7:4], g[7:4], b[7:4]});
            end
            applyStimulus(1'b1, 1'b1, 1'b1, r, g, b);
        end
        if (m_cap && len != H) begin
            m_line_err = 1'b1;
        end
        m_lines++;
        if (blank) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
            applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
            applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
            applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        end
    endtask

    task automatic send_vsync();
        if (m_cap) begin
            m_exp_done++;
            m_lines_seen = m_lines;
            if (m_lines != V) begin
                m_frame_err = 1'b1;
            end
            m_cap   = 1'b0;
            m_armed = continuous;
        end else if (m_armed) begin
            m_cap   = 1'b1;
            m_armed = 1'b0;
        end
        m_lines = 0;
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic send_frame(input int nlines, input int bad_line, input int bad_len, input bit last_blank);
        for (int l = 0; l < nlines; l++) begin
            send_line((l == bad_line) ? bad_len : H, (l == nlines - 1) ? last_blank : 1'b1);
        end
    endtask

    task automatic pulse_start();
        if (!m_armed && !m_cap) begin
            m_armed     = 1'b1;
            m_line_err  = 1'b0;
            m_frame_err = 1'b0;
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain();
        pix_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag);
        checkOutput({tag, " pending writes"}, 32'(exp_addr.size()), 32'd0);
        checkOutput({tag, " frame_done count"}, 32'(done_cnt), 32'(m_exp_done));
        checkOutput({tag, " lines_seen"}, 32'(lines_seen), 32'(m_lines_seen));
        checkOutput({tag, " line_err"}, 32'(line_err), 32'(m_line_err));
        checkOutput({tag, " frame_err"}, 32'(frame_err), 32'(m_frame_err));
        checkOutput({tag, " busy"}, 32'(busy), 32'(m_armed || m_cap));
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, " wr_en"}, 32'(wr_en), 32'd0);
        checkOutput({tag, " wr_addr"}, 32'(wr_addr), 32'd0);
        checkOutput({tag, " wr_data"}, 32'(wr_data), 32'd0);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " frame_done"}, 32'(frame_done), 32'd0);
        checkOutput({tag, " line_err"}, 32'(line_err), 32'd0);
        checkOutput({tag, " frame_err"}, 32'(frame_err), 32'd0);
        checkOutput({tag, " lines_seen"}, 32'(lines_seen), 32'd0);
    endtask

    initial begin
        int wc0;
        int dc0;

        reset      = 1'b1;
        pix_en     = 1'b0;
        start      = 1'b0;
        continuous = 1'b0;
        hsync      = 1'b1;
        vsync      = 1'b1;
        valid      = 1'b0;
        red        = '0;
        green      = '0;
        blue       = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // Reset held for 3 clk in the middle of a captured frame aborts it.
        $display("[TB] test 1: reset mid-frame");
        pulse_start();
        send_vsync();
        send_frame(3, -1, H, 1'b1);
        drain();
        checkOutput("t1 busy before reset", 32'(busy), 32'd1);
        reset  = 1'b1;
        pix_en = 1'b1;
        valid  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("t1 in reset");
        reset        = 1'b0;
        pix_en       = 1'b0;
        valid        = 1'b0;
        m_cap        = 1'b0;
        m_armed      = 1'b0;
        m_line_err   = 1'b0;
        m_frame_err  = 1'b0;
        m_lines      = 0;
        m_lines_seen = 0;
        send_frame(2, -1, H, 1'b1);
        send_vsync();
        send_frame(2, -1, H, 1'b1);
        send_vsync();
        drain();
        check_status("t1");

        // Full frame, including the fixed probe pixel at (5,7) and a start ignored mid-frame.
        $display("[TB] test 2: full frame");
        wc0 = write_cnt;
        probe_seen = 1'b0;
        pulse_start();
        send_vsync();
        send_frame(4, -1, H, 1'b1);
        pulse_start();
        send_frame(V - 4, -1, H, 1'b1);
        send_vsync();
        drain();
        checkOutput("t2 write count", 32'(write_cnt - wc0), 32'(H * V));
        checkOutput("t2 probe seen", 32'(probe_seen), 32'd1);
        checkOutput("t2 probe data", 32'(probe_data), 32'h00000A3F);
        checkOutput("t2 lines_seen", 32'(lines_seen), 32'(V));
        check_status("t2");

        // One short line flags line_err; a later start inside the frame must not clear it.
        $display("[TB] test 3: short line");
        pulse_start();
        send_vsync();
        send_frame(3, -1, H, 1'b1);
        checkOutput("t3 line_err before", 32'(line_err), 32'd0);
        send_line(H - 1, 1'b1);
        checkOutput("t3 line_err after", 32'(line_err), 32'd1);
        pulse_start();
        send_frame(V - 4, -1, H, 1'b1);
        send_vsync();
        drain();
        check_status("t3");

        // Short frame sets frame_err; without continuous the next frame is not captured.
        $display("[TB] test 4: short frame");
        pulse_start();
        send_vsync();
        send_frame(V - 2, -1, H, 1'b1);
        send_vsync();
        drain();
        checkOutput("t4 lines_seen", 32'(lines_seen), 32'(V - 2));
        checkOutput("t4 frame_err", 32'(frame_err), 32'd1);
        check_status("t4a");
        wc0 = write_cnt;
        send_frame(V, -1, H, 1'b1);
        send_vsync();
        drain();
        checkOutput("t4 writes after idle", 32'(write_cnt - wc0), 32'd0);
        check_status("t4b");

        // Continuous capture re-arms after each frame and restarts at address {0,0}.
        $display("[TB] test 5: continuous");
        dc0 = done_cnt;
        continuous = 1'b1;
        pulse_start();
        send_vsync();
        send_frame(V, 0, H + 3, 1'b1);
        send_vsync();
        first_seen = 1'b0;
        send_frame(V, -1, H, 1'b1);
        send_vsync();
        send_frame(V, -1, H, 1'b1);
        continuous = 1'b0;
        send_vsync();
        drain();
        checkOutput("t5 done pulses", 32'(done_cnt - dc0), 32'd2);
        checkOutput("t5 frame2 first write seen", 32'(first_seen), 32'd1);
        checkOutput("t5 frame2 first addr", 32'(first_addr), 32'd0);
        check_status("t5");

        // Sparse pix_en: same write set, never two write strobes in a row.
        $display("[TB] test 6: pix_en 1 of 4");
        wc0 = write_cnt;
        pix_div = 4;
        pulse_start();
        send_vsync();
        send_frame(V, -1, H, 1'b1);
        send_vsync();
        drain();
        pix_div = 1;
        checkOutput("t6 write count", 32'(write_cnt - wc0), 32'(H * V));
        check_status("t6");

        // Last line's valid falls on the same pixel as vsync asserts: that line still counts.
        $display("[TB] test 7: line end coincides with vsync");
        pulse_start();
        send_vsync();
        send_frame(V, -1, H, 1'b0);
        send_vsync();
        drain();
        checkOutput("t7 lines_seen", 32'(lines_seen), 32'(V));
        checkOutput("t7 frame_err", 32'(frame_err), 32'd0);
        check_status("t7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
